dmem_responder: RTL and testbench



---
 rtl/dmem_pkg.sv | 23 ++
 rtl/dmem_array.sv | 39 +++
 rtl/dmem_responder.sv | 170 +++++++++++++++++
 tb/tb_dmem_responder.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, lane geometry
// and a constant-evaluable ceiling log2.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int LANE_W   = 8;
  localparam int WORD_OFF = 2;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 data array with per-byte write enables and a registered read port.
// The read register can be loaded with zero so rejected loads return a clean value.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wrEn,
  input  logic [3:0]    byteEn,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wrData,
  input  logic          rdEn,
  input  logic          rdZero,
  output logic [31:0]   rdData
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wrEn) begin
      for (int i = 0; i < 4; i++) begin
        if (byteEn[i]) mem[addr][i*LANE_W +: LANE_W] <= wrData[i*LANE_W +: LANE_W];
      end
    end
  end

  // Array contents are never reset; only the returned word is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdData <= '0;
    end else if (rdEn) begin
      rdData <= rdZero ? '0 : mem[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the M stage: stalls the pipe for LATENCY cycles,
// then pulses rsp_valid. Optional address range check under `DMEM_RANGE_CHECK_EN.
//
// state | meaning
// IDLE  | no request outstanding; a req_valid here is accepted and stalls immediately
// WAIT  | latency countdown on the latched request, stall held
// RESP  | access committed on entry; rsp_valid pulse, stall released
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH     = 1024,
  parameter int          LATENCY   = 2,
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic        req_sb,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall_o,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = (clog2(LATENCY) < 1) ? 1 : clog2(LATENCY);
  localparam logic [CW-1:0] CNT_INIT = CW'((LATENCY > 1) ? LATENCY - 2 : 0);

  state_t        state;
  state_t        stateNext;
  logic [CW-1:0] cnt;

  logic          latWe;
  logic          latSb;
  logic          latErr;
  logic [1:0]    latLane;
  logic [AW-1:0] latIdx;
  logic [31:0]   latWdata;

  logic [AW-1:0] reqIdx;
  logic          reqErr;
  logic          accept;
  logic          commit;

  logic          curWe;
  logic          curSb;
  logic          curErr;
  logic [1:0]    curLane;
  logic [AW-1:0] curIdx;
  logic [31:0]   curWdata;
  logic [3:0]    byteEn;
  logic [31:0]   arrWdata;

`ifdef DMEM_RANGE_CHECK_EN
  logic [31:0] offset;
  logic        unusedOffset;

  assign offset       = req_addr - BASE_ADDR;
  assign reqErr       = |offset[31:AW+2];
  assign reqIdx       = offset[AW+1:WORD_OFF];
  assign unusedOffset = ^offset[WORD_OFF-1:0];
`else
  logic unusedAddr;

  assign reqErr     = 1'b0;
  assign reqIdx     = req_addr[AW+1:WORD_OFF];
  assign unusedAddr = ^{req_addr[31:AW+2], BASE_ADDR};
`endif

  assign accept = (state == IDLE) && req_valid;

  // With LATENCY=1 the commit edge is the accept edge, so the live request feeds the array.
  always_comb begin
    curWe    = latWe;
    curSb    = latSb;
    curErr   = latErr;
    curLane  = latLane;
    curIdx   = latIdx;
    curWdata = latWdata;
    if (state == IDLE) begin
      curWe    = req_we;
      curSb    = req_sb;
      curErr   = reqErr;
      curLane  = req_addr[WORD_OFF-1:0];
      curIdx   = reqIdx;
      curWdata = req_wdata;
    end
  end

  assign commit   = (accept && (LATENCY == 1)) || ((state == WAIT) && (cnt == '0));
  assign byteEn   = (curWe && curSb) ? (4'b0001 << curLane) : 4'b1111;
  assign arrWdata = (curWe && curSb) ? {4{curWdata[LANE_W-1:0]}} : curWdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      latWe    <= 1'b0;
      latSb    <= 1'b0;
      latErr   <= 1'b0;
      latLane  <= '0;
      latIdx   <= '0;
      latWdata <= '0;
    end else if (accept) begin
      latWe    <= req_we;
      latSb    <= req_sb;
      latErr   <= reqErr;
      latLane  <= req_addr[WORD_OFF-1:0];
      latIdx   <= reqIdx;
      latWdata <= req_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= CNT_INIT;
    end else if ((state == WAIT) && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: if (req_valid) stateNext = (LATENCY == 1) ? RESP : WAIT;
      WAIT: if (cnt == '0) stateNext = RESP;
      RESP: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    stall_o   = 1'b0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    case (state)
      IDLE: stall_o = req_valid;
      WAIT: stall_o = 1'b1;
      RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = latErr;
      end
      default: ;
    endcase
  end

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk    (clk),
    .rst_n  (rst_n),
    .wrEn   (commit && curWe && !curErr),
    .byteEn (byteEn),
    .addr   (curIdx),
    .wrData (arrWdata),
    .rdEn   (commit && !curWe),
    .rdZero (curErr),
    .rdData (rsp_rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (LATENCY=2, DEPTH=1024, BASE_ADDR=0); range-check
// cases run only when DMEM_RANGE_CHECK_EN is defined.
`timescale 1ns/1ps
module tb_dmem_responder;
  localparam int DEPTH   = 1024;
  localparam int LATENCY = 2;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we    = 1'b0;
  logic        req_sb    = 1'b0;
  logic [31:0] req_addr  = '0;
  logic [31:0] req_wdata = '0;
  logic        stall_o;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] rd;
  logic        er;

  always #5 clk = ~clk;

  dmem_responder #(
    .DEPTH     (DEPTH),
    .LATENCY   (LATENCY),
    .BASE_ADDR (32'h0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_sb    (req_sb),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .stall_o   (stall_o),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One request from IDLE to response; checks stall window, latency and pulse width.
  task automatic doReq(input logic we, input logic sb, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic [31:0] rdata, output logic err);
    int lat;
    int stalls;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_sb    = sb;
    req_addr  = addr;
    req_wdata = wdata;
    #1;
    checkVal("stall_on_accept", 32'(stall_o), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = ~we;
    req_sb    = 1'b0;
    req_addr  = 32'hFFFF_FFF0;
    req_wdata = 32'h5555_5555;
    lat    = 1;
    stalls = 1;
    while (!rsp_valid && lat < 20) begin
      if (stall_o) stalls++;
      @(posedge clk);
      #1;
      lat++;
    end
    checkVal("rsp_seen", 32'(rsp_valid), 32'd1);
    checkVal("latency", lat, LATENCY);
    checkVal("stall_cycles", stalls, LATENCY);
    checkVal("rsp_stall_low", 32'(stall_o), 32'd0);
    rdata = rsp_rdata;
    err   = rsp_err;
    @(posedge clk);
    #1;
    checkVal("rsp_pulse_end", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] lastWord;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkVal("idle_flags", {29'b0, rsp_valid, stall_o, rsp_err}, 32'd0);
      checkVal("idle_rdata", rsp_rdata, 32'd0);
    end

    doReq(1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF, rd, er);
    checkVal("store_keeps_rdata", rd, 32'h0);
    checkVal("store_err", 32'(er), 32'd0);
    doReq(1'b0, 1'b0, 32'h10, 32'h0, rd, er);
    checkVal("load_0x10", rd, 32'hDEAD_BEEF);
    checkVal("load_err", 32'(er), 32'd0);

    doReq(1'b1, 1'b0, 32'h10, 32'h1122_3344, rd, er);
    checkVal("rdata_hold_after_store", rd, 32'hDEAD_BEEF);
    doReq(1'b1, 1'b1, 32'h13, 32'hFFFF_FFA5, rd, er);
    doReq(1'b0, 1'b0, 32'h10, 32'h0, rd, er);
    checkVal("sb_lane3", rd, 32'hA522_3344);
    doReq(1'b1, 1'b1, 32'h11, 32'h0000_005A, rd, er);
    doReq(1'b0, 1'b1, 32'h12, 32'h0, rd, er);
    checkVal("sb_lane1_unaligned_load", rd, 32'hA522_5A44);
    lastWord = 32'hA522_5A44;

`ifndef DMEM_RANGE_CHECK_EN
    doReq(1'b1, 1'b0, 32'h0000_1010, 32'h1234_5678, rd, er);
    doReq(1'b0, 1'b0, 32'h10, 32'h0, rd, er);
    checkVal("addr_alias", rd, 32'h1234_5678);
    checkVal("alias_err", 32'(er), 32'd0);
    lastWord = 32'h1234_5678;
`endif

    // req_valid held high: acceptances only from IDLE, pulses LATENCY+1 apart.
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_sb    = 1'b0;
    req_addr  = 32'h10;
    @(posedge clk);
    #1;
    for (int k = 1; k <= 9; k++) begin
      if (k > 1) begin
        @(posedge clk);
        #1;
      end
      checkVal("b2b_valid", 32'(rsp_valid), 32'(k % 3 == 2));
      checkVal("b2b_stall", 32'(stall_o), 32'(k % 3 != 2));
      if (k % 3 == 2) checkVal("b2b_rdata", rsp_rdata, lastWord);
    end
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkVal("b2b_drained", {30'b0, rsp_valid, stall_o}, 32'd0);

    // Reset during WAIT of a store must abort it.
    doReq(1'b1, 1'b0, 32'h20, 32'h0, rd, er);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_sb    = 1'b0;
    req_addr  = 32'h20;
    req_wdata = 32'h0000_00FF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    checkVal("pre_rst_wait_stall", 32'(stall_o), 32'd1);
    rst_n = 1'b0;
    #1;
    checkVal("rst_stall", 32'(stall_o), 32'd0);
    checkVal("rst_valid", 32'(rsp_valid), 32'd0);
    checkVal("rst_rdata", rsp_rdata, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    doReq(1'b0, 1'b0, 32'h20, 32'h0, rd, er);
    checkVal("rst_no_commit", rd, 32'h0);

`ifdef DMEM_RANGE_CHECK_EN
    doReq(1'b1, 1'b0, 32'hFFC, 32'hCAFE_F00D, rd, er);
    checkVal("rc_inrange_store_err", 32'(er), 32'd0);
    doReq(1'b1, 1'b0, 32'h0, 32'h7777_7777, rd, er);
    doReq(1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0BAD_0BAD, rd, er);
    checkVal("rc_oor_store_err", 32'(er), 32'd1);
    doReq(1'b0, 1'b0, 32'hFFC, 32'h0, rd, er);
    checkVal("rc_store_suppressed", rd, 32'hCAFE_F00D);
    checkVal("rc_inrange_load_err", 32'(er), 32'd0);
    doReq(1'b0, 1'b0, 32'h0000_1000, 32'h0, rd, er);
    checkVal("rc_oor_load_rdata", rd, 32'h0);
    checkVal("rc_oor_load_err", 32'(er), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
